// File: rtl/tx_pkg.sv
// Shared types and constants for the TX redundant burst scheduler.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {
    SPD_NONE = 2'b00,
    SPD_10   = 2'b01,
    SPD_100  = 2'b10,
    SPD_1000 = 2'b11
  } speed_t;

  // Divider terminal counts: one strobe per (tc+1) cycles.
  localparam int unsigned DIV_TC_100 = 9;
  localparam int unsigned DIV_TC_10  = 99;

  localparam int unsigned FRAME_LIMIT_DEF = 57600;

endpackage

// File: rtl/tx_adv_strobe.sv
// Speed-dependent byte-advance strobe; the divider restarts on any speed change.
module tx_adv_strobe
  import tx_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] speed,
  output logic       adv_data
);

  speed_t     speed_q;
  logic [6:0] div;
  logic [6:0] tc;

  always_comb begin
    tc = '0;
    case (speed_q)
      SPD_100: tc = 7'(DIV_TC_100);
      SPD_10:  tc = 7'(DIV_TC_10);
      default: tc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      speed_q  <= SPD_NONE;
      div      <= '0;
      adv_data <= 1'b0;
    end else if (speed != speed_q) begin
      speed_q  <= speed_t'(speed);
      div      <= '0;
      adv_data <= 1'b0;
    end else begin
      div <= (div >= tc) ? '0 : div + 7'd1;
      case (speed_q)
        SPD_1000:        adv_data <= 1'b1;
        SPD_100, SPD_10: adv_data <= (div == '0);
        default:         adv_data <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/tx_redundant_scheduler.sv
// Periodic burst scheduler: issues N identical frames per period via start/busy,
// with inter-copy gap, copy tagging, address wrap and overrun accounting.
module tx_redundant_scheduler
  import tx_pkg::*;
#(
  parameter int unsigned MAX_COPIES  = 7,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned GAP_W       = 17,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned FRAME_LIMIT = FRAME_LIMIT_DEF,
  parameter int unsigned ID_W        = 8,
  parameter int unsigned OVR_W       = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic [2:0]        copies,
  input  logic [GAP_W-1:0]  gap,
  input  logic [1:0]        speed,
  input  logic              busy,
  input  logic [ADDR_W-1:0] lastaddr,
  output logic              start,
  output logic [ID_W-1:0]   txid,
  output logic [ADDR_W-1:0] startaddr,
  output logic              adv_data,
  output logic              burst_active,
  output logic [15:0]       seq,
  output logic [OVR_W-1:0]  overrun_cnt
);

  localparam logic [2:0] MAX_C = 3'(MAX_COPIES);

  state_t            state, state_next;
  logic [CNT_W-1:0]  pcnt;
  logic              tick;
  logic [GAP_W-1:0]  gcnt, gap_l;
  logic [2:0]        copies_c, copies_l, copy_idx;

  assign tick = enable && (pcnt == period);

  always_comb begin
    copies_c = copies;
    if (copies == 3'd0)       copies_c = 3'd1;
    else if (copies > MAX_C)  copies_c = MAX_C;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)               pcnt <= '0;
    else if (!enable || tick) pcnt <= '0;
    else                     pcnt <= pcnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (tick) state_next = ST_GAP;
      ST_GAP:       if (gcnt >= gap_l && !busy) state_next = ST_ISSUE;
      ST_ISSUE:     state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (busy) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy) state_next = (copy_idx == copies_l) ? ST_IDLE : ST_GAP;
      default:      state_next = ST_IDLE;
    endcase
  end

  // start/txid/copy_idx are loaded on the GAP->ISSUE edge so the registered
  // outputs are valid during the ISSUE cycle itself.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      start        <= 1'b0;
      txid         <= '0;
      startaddr    <= '0;
      burst_active <= 1'b0;
      seq          <= '0;
      overrun_cnt  <= '0;
      gcnt         <= '0;
      gap_l        <= '0;
      copies_l     <= '0;
      copy_idx     <= '0;
    end else begin
      start        <= 1'b0;
      burst_active <= (state_next != ST_IDLE);
      if (tick && state != ST_IDLE && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            copies_l  <= copies_c;
            gap_l     <= gap;
            startaddr <= (lastaddr >= ADDR_W'(FRAME_LIMIT)) ? '0 : lastaddr;
            copy_idx  <= '0;
            gcnt      <= '0;
          end
        end
        ST_GAP: begin
          if (gcnt != '1) gcnt <= gcnt + GAP_W'(1);
          if (state_next == ST_ISSUE) begin
            start    <= 1'b1;
            txid     <= ID_W'(copy_idx + 3'd1);
            copy_idx <= copy_idx + 3'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!busy) begin
            if (copy_idx == copies_l) seq  <= seq + 16'd1;
            else                      gcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  tx_adv_strobe u_adv (
    .clk      (clk),
    .rstb     (rstb),
    .speed    (speed),
    .adv_data (adv_data)
  );

endmodule

// File: tb/tb_tx_redundant_scheduler.sv
// Scoreboard bench for tx_redundant_scheduler with a busy-holding generator model.
module tb_tx_redundant_scheduler;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0;
  logic [26:0] period = '0;
  logic [2:0]  copies = '0;
  logic [16:0] gap = '0;
  logic [1:0]  speed = '0;
  logic        busy = 1'b0;
  logic [19:0] lastaddr = '0;
  logic        start;
  logic [7:0]  txid;
  logic [19:0] startaddr;
  logic        adv_data;
  logic        burst_active;
  logic [15:0] seq;
  logic [3:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold     = 20;
  bit gen_kill = 1'b0;
  int exp_seq  = 0;

  typedef struct {
    logic [7:0]  id;
    logic [19:0] addr;
  } exp_t;
  exp_t sb[$];
  int   start_log[$];

  tx_redundant_scheduler #(
    .MAX_COPIES (5),
    .OVR_W      (4)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .enable       (enable),
    .period       (period),
    .copies       (copies),
    .gap          (gap),
    .speed        (speed),
    .busy         (busy),
    .lastaddr     (lastaddr),
    .start        (start),
    .txid         (txid),
    .startaddr    (startaddr),
    .adv_data     (adv_data),
    .burst_active (burst_active),
    .seq          (seq),
    .overrun_cnt  (overrun_cnt)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame generator: raises busy in the start cycle and holds it `hold` cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (start === 1'b1) begin
        busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          if (gen_kill) break;
        end
        busy = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every start pops one expected (txid, startaddr).
  initial begin
    forever begin
      @(posedge clk); #1;
      if (start === 1'b1) begin
        exp_t e;
        start_log.push_back(cyc);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_start cyc=%0d txid=%0d expected no start", cyc, txid);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (txid !== e.id) begin
            n_fail++;
            $display("FAIL sb_txid cyc=%0d got=%0d want=%0d", cyc, txid, e.id);
          end
          n_checks++;
          if (startaddr !== e.addr) begin
            n_fail++;
            $display("FAIL sb_startaddr cyc=%0d got=%0d want=%0d", cyc, startaddr, e.addr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic collect(input int max_cyc, input bit drop_at_start, input bit drop_at_end,
                         output int nstarts, output int first_cyc);
    bit seen = 1'b0;
    nstarts   = 0;
    first_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (start === 1'b1) begin
        nstarts++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          if (drop_at_start) enable = 1'b0;
        end
      end
      if (burst_active === 1'b1) seen = 1'b1;
      else if (seen) begin
        if (drop_at_end) enable = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #20;
    n_checks++;
    if ({start, adv_data, burst_active} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000", {start, adv_data, burst_active});
    end
    n_checks++;
    if (txid !== 8'd0) begin n_fail++; $display("FAIL reset_txid got=%0d want=0", txid); end
    n_checks++;
    if (startaddr !== 20'd0) begin n_fail++; $display("FAIL reset_startaddr got=%0d want=0", startaddr); end
    n_checks++;
    if (seq !== 16'd0) begin n_fail++; $display("FAIL reset_seq got=%0d want=0", seq); end
    n_checks++;
    if (overrun_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_overrun got=%0d want=0", overrun_cnt); end
    step(); step();
    rstb = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int e, n, f;
    period = 27'd99; copies = 3'd3; gap = '0; hold = 20; lastaddr = 20'd1000;
    for (int b = 0; b < 2; b++)
      for (int k = 1; k <= 3; k++) sb.push_back('{id: 8'(k), addr: 20'd1000});
    start_log.delete();
    step();
    enable = 1'b1;
    e = cyc;
    collect(400, 1'b0, 1'b0, n, f);
    exp_seq++;
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL basic_starts1 got=%0d want=3", n); end
    n_checks++;
    if (f !== e + 101) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", f - e, 101); end
    n_checks++;
    if (start_log.size() < 2 || start_log[1] - start_log[0] !== 22) begin
      n_fail++;
      $display("FAIL basic_spacing got_entries=%0d want spacing 22", start_log.size());
    end
    n_checks++;
    if (seq !== 16'(exp_seq)) begin n_fail++; $display("FAIL basic_seq1 got=%0d want=%0d", seq, exp_seq); end
    collect(400, 1'b1, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL basic_starts2 got=%0d want=3", n); end
    n_checks++;
    if (f !== e + 201) begin n_fail++; $display("FAIL basic_period got=%0d want=%0d", f - e, 201); end
    n_checks++;
    if (seq !== 16'(exp_seq)) begin n_fail++; $display("FAIL basic_seq2 got=%0d want=%0d", seq, exp_seq); end
    n_checks++;
    if (overrun_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_overrun got=%0d want=0", overrun_cnt); end
  endtask

  task automatic test_gap();
    int e, n, f;
    period = 27'd19; copies = 3'd2; gap = 17'd3; hold = 10; lastaddr = 20'd333;
    sb.push_back('{id: 8'd1, addr: 20'd333});
    sb.push_back('{id: 8'd2, addr: 20'd333});
    start_log.delete();
    step();
    enable = 1'b1;
    e = cyc;
    collect(300, 1'b1, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (f !== e + 24) begin n_fail++; $display("FAIL gap_latency got=%0d want=24", f - e); end
    n_checks++;
    if (start_log.size() < 2 || start_log[1] - start_log[0] !== 15) begin
      n_fail++;
      $display("FAIL gap_spacing got_entries=%0d want spacing 15", start_log.size());
    end
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL gap_starts got=%0d want=2", n); end
    gap = '0;
  endtask

  task automatic test_clamp();
    int n, f;
    period = 27'd19; hold = 5; lastaddr = 20'd444;
    copies = 3'd0;
    sb.push_back('{id: 8'd1, addr: 20'd444});
    step();
    enable = 1'b1;
    collect(300, 1'b1, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL clamp_zero_starts got=%0d want=1", n); end
    n_checks++;
    if (seq !== 16'(exp_seq)) begin n_fail++; $display("FAIL clamp_zero_seq got=%0d want=%0d", seq, exp_seq); end
    copies = 3'd7;
    for (int k = 1; k <= 5; k++) sb.push_back('{id: 8'(k), addr: 20'd444});
    step();
    enable = 1'b1;
    collect(300, 1'b1, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL clamp_max_starts got=%0d want=5", n); end
    n_checks++;
    if (txid !== 8'd5) begin n_fail++; $display("FAIL clamp_txid_hold got=%0d want=5", txid); end
  endtask

  task automatic test_overrun();
    int n, f;
    period = 27'd9; copies = 3'd1; gap = '0; lastaddr = 20'd10;
    // Busy for 48 cycles puts the WAIT_DONE->IDLE cycle on a tick.
    hold = 48;
    sb.push_back('{id: 8'd1, addr: 20'd10});
    step();
    enable = 1'b1;
    collect(300, 1'b0, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL overrun_starts got=%0d want=1", n); end
    n_checks++;
    if (overrun_cnt !== 4'd5) begin n_fail++; $display("FAIL overrun_count got=%0d want=5", overrun_cnt); end
    hold = 120;
    sb.push_back('{id: 8'd1, addr: 20'd10});
    step();
    enable = 1'b1;
    collect(400, 1'b0, 1'b1, n, f);
    exp_seq++;
    n_checks++;
    if (overrun_cnt !== 4'hF) begin n_fail++; $display("FAIL overrun_saturate got=%0d want=15", overrun_cnt); end
  endtask

  task automatic test_addr_wrap();
    int n, f;
    logic [19:0] in_a[3];
    logic [19:0] exp_a[3];
    in_a[0] = 20'd57599; exp_a[0] = 20'd57599;
    in_a[1] = 20'd57600; exp_a[1] = 20'd0;
    in_a[2] = 20'd60000; exp_a[2] = 20'd0;
    period = 27'd9; copies = 3'd1; hold = 5;
    for (int i = 0; i < 3; i++) begin
      lastaddr = in_a[i];
      sb.push_back('{id: 8'd1, addr: exp_a[i]});
      step();
      enable = 1'b1;
      collect(200, 1'b1, 1'b1, n, f);
      exp_seq++;
      n_checks++;
      if (startaddr !== exp_a[i]) begin
        n_fail++;
        $display("FAIL addr_wrap_%0d got=%0d want=%0d", i, startaddr, exp_a[i]);
      end
    end
    n_checks++;
    if (seq !== 16'(exp_seq)) begin n_fail++; $display("FAIL addr_seq got=%0d want=%0d", seq, exp_seq); end
  endtask

  task automatic test_speed();
    int cnt;
    enable = 1'b0;
    step();
    speed = 2'b10;
    step();
    n_checks++;
    if (adv_data !== 1'b0) begin n_fail++; $display("FAIL speed100_restart got=%b want=0", adv_data); end
    step();
    n_checks++;
    if (adv_data !== 1'b1) begin n_fail++; $display("FAIL speed100_first got=%b want=1", adv_data); end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin step(); if (adv_data === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 10) begin n_fail++; $display("FAIL speed100_rate got=%0d want=10", cnt); end
    speed = 2'b01;
    step(); step();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin step(); if (adv_data === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 10) begin n_fail++; $display("FAIL speed10_rate got=%0d want=10", cnt); end
    speed = 2'b00;
    step(); step();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin step(); if (adv_data === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 0) begin n_fail++; $display("FAIL speed_none_rate got=%0d want=0", cnt); end
    speed = 2'b11;
    step(); step();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin step(); if (adv_data === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 50) begin n_fail++; $display("FAIL speed1000_rate got=%0d want=50", cnt); end
  endtask

  task automatic test_reset_mid_burst();
    int n, f, r, seen;
    period = 27'd99; copies = 3'd3; gap = '0; hold = 20; lastaddr = 20'd2000;
    sb.push_back('{id: 8'd1, addr: 20'd2000});
    sb.push_back('{id: 8'd2, addr: 20'd2000});
    step();
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 400 && seen < 2; i++) begin
      step();
      if (start === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 2) begin n_fail++; $display("FAIL rstmid_reach_copy2 got=%0d want=2", seen); end
    repeat (5) step();
    #2;
    rstb = 1'b0;
    gen_kill = 1'b1;
    #1;
    n_checks++;
    if ({start, adv_data, burst_active} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_flags got=%b want=000", {start, adv_data, burst_active});
    end
    n_checks++;
    if (txid !== 8'd0 || startaddr !== 20'd0) begin
      n_fail++;
      $display("FAIL rstmid_txid_addr got=%0d/%0d want=0/0", txid, startaddr);
    end
    n_checks++;
    if (seq !== 16'd0 || overrun_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_counters got=%0d/%0d want=0/0", seq, overrun_cnt);
    end
    step(); step();
    gen_kill = 1'b0;
    step();
    rstb = 1'b1;
    r = cyc;
    for (int k = 1; k <= 3; k++) sb.push_back('{id: 8'(k), addr: 20'd2000});
    collect(400, 1'b1, 1'b1, n, f);
    n_checks++;
    if (f !== r + 101) begin n_fail++; $display("FAIL rstmid_latency got=%0d want=101", f - r); end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL rstmid_starts got=%0d want=3", n); end
    n_checks++;
    if (seq !== 16'd1) begin n_fail++; $display("FAIL rstmid_seq got=%0d want=1", seq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_clamp();
    test_overrun();
    test_addr_wrap();
    test_speed();
    test_reset_mid_burst();
    repeat (20) step();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_redundant_scheduler.md
# tx_redundant_scheduler

Parametrised burst scheduler for the Ethernet TX path. Every `period+1` cycles it issues a burst of `copies` identical frames to the frame generator through the `start`/`busy` handshake. It separates the copies by a programmable gap and tags each copy with `txid`. It also advances the video start address with wrap-around, produces the speed-dependent `adv_data` strobe, and counts bursts that were dropped because the previous burst was still running.

## Interface
Parameters:
- `MAX_COPIES`, 7: upper clamp on copies per burst.
- `CNT_W`, 27: width of the period counter.
- `GAP_W`, 17: width of the inter-copy gap counter.
- `ADDR_W`, 20: width of the frame start address.
- `FRAME_LIMIT`, 57600: address at or above which `startaddr` wraps to 0.
- `ID_W`, 8: width of `txid`.
- `OVR_W`, 16: width of the overrun counter.

Ports:
- `clk` in 1: single clock, 125 MHz TX domain.
- `rstb` in 1: reset, asynchronous, active-low.
- `enable` in 1: arms the period counter.
- `period` in CNT_W: burst period minus 1, in cycles.
- `copies` in 3: copies per burst; 0 is treated as 1; values above MAX_COPIES are clamped to MAX_COPIES.
- `gap` in GAP_W: minimum idle cycles before each copy.
- `speed` in 2: link speed; 11 = 1000M, 10 = 100M, 01 = 10M, 00 = no link.
- `busy` in 1: frame generator busy.
- `lastaddr` in ADDR_W: generator's end address of the last frame.
- `start` out 1: one-cycle request to send a frame.
- `txid` out ID_W: copy index, 1..copies.
- `startaddr` out ADDR_W: frame start address for the current burst.
- `adv_data` out 1: byte-advance strobe.
- `burst_active` out 1: high while the FSM is outside IDLE.
- `seq` out 16: count of completed bursts.
- `overrun_cnt` out OVR_W: count of dropped ticks, saturating.

## Operation
- **Period counter** (`pcnt`):
  - While `enable` is low, `pcnt` = 0.
  - Otherwise it increments each cycle. When `pcnt == period`, `tick` is asserted for one cycle and `pcnt` returns to 0.
- **FSM states:** IDLE, GAP, ISSUE, WAIT_ACK, WAIT_DONE.
- **IDLE:**
  - On `tick`, latch `copies_l` (clamped as above) and `gap_l`.
  - Set `startaddr` to 0 if `lastaddr >= FRAME_LIMIT`, else to `lastaddr`.
  - Set `copy_idx` = 0, `gcnt` = 0, then go to GAP.
- **GAP:**
  - `gcnt` increments each cycle.
  - When `gcnt >= gap_l` and `busy` is low, go to ISSUE.
- **ISSUE:**
  - `start` = 1 for this cycle only.
  - `txid` ← `copy_idx+1`, `copy_idx` ← `copy_idx+1`, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `busy` = 1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `busy` = 0.
  - If `copy_idx == copies_l`: `seq` +1 (wraps modulo 2^16), go to IDLE.
  - Otherwise: `gcnt` ← 0, go to GAP.
- **Overrun:**
  - A `tick` arriving while not in IDLE is dropped.
  - `overrun_cnt` +1, saturating at all-ones.
- **Enable dropped mid-burst:** the current burst completes normally; no further ticks occur.
- **`adv_data` generation:**
  - speed 11: 1 every cycle.
  - speed 10: 1 cycle in 10.
  - speed 01: 1 cycle in 100.
  - speed 00: constant 0.
  - When speed changes, the divider restarts at 0.
- **Output hold behaviour:**
  - `txid` and `startaddr` hold their values between events.
  - `txid` is valid from ISSUE until the next ISSUE.

## Timing
- **Reset values:**
  - `start`, `adv_data`, `burst_active` = 0.
  - `txid`, `startaddr`, `seq`, `overrun_cnt` = 0.
  - FSM = IDLE; `pcnt`, `gcnt`, divider = 0.
- **Outputs are registered.**
- **Reset mid-burst:** FSM returns to IDLE immediately and any pending copies are abandoned. `start` deasserts asynchronously.
- **Start latency:** with `tick` in cycle T, `gap` = 0 and `busy` low, `start` is high in cycle T+2. Each unit of `gap` adds one cycle.
- **Spacing between copies:** after `busy` falls in cycle D, the next `start` comes no earlier than D+2+`gap`.
- **Simultaneous events:**
  - `tick` in the same cycle the FSM returns to IDLE (WAIT_DONE→IDLE) counts as an overrun.
  - `tick` while already in IDLE starts a burst.
- **`period` = 0:** a tick every cycle while enabled.
- **`busy` never rises after ISSUE:** the FSM stays in WAIT_ACK. This is intended; the generator guarantees acknowledgement.
- **`adv_data` divider:** the first strobe after a speed change comes in the cycle after the divider restart.

## Structure
- **Package `tx_pkg`:**
  - FSM state enum.
  - Speed codes SPD_1000/100/10/NONE.
  - Divider terminal counts 9 and 99.
  - Default FRAME_LIMIT.
- **Sub-module `tx_adv_strobe`:** inputs `clk`, `rstb`, `speed`; output `adv_data`. This is the divider, instantiated once.
- **Period counter and FSM** live in the top of this block.

## Test plan
1. **Basic 3-copy burst:** `period`=99, `copies`=3, `gap`=0, generator model holding `busy` high for 20 cycles per start → `start` pulses with `txid` 1, 2, 3; `seq` = 1 after the burst; next burst starts 100 cycles after the first tick.
2. **Copy clamping:** `copies`=0 → one copy, `txid`=1. `copies`=7 with MAX_COPIES=5 → exactly 5 starts.
3. **Overrun:** `period`=9 with `busy` held 50 cycles → `overrun_cnt` increments per dropped tick. Force `overrun_cnt` near all-ones → it holds at all-ones.
4. **Address wrap:**
   - `lastaddr`=57599 at tick → `startaddr`=57599.
   - `lastaddr`=57600 → `startaddr`=0.
   - `lastaddr`=60000 → `startaddr`=0.
5. **Speed strobes:**
   - speed 10 → `adv_data` high 1 of 10 cycles.
   - speed 01 → high 1 of 100 cycles.
   - speed 00 → always 0.
   - speed 11 → always 1.
6. **Reset mid-burst:** assert `rstb`=0 during WAIT_DONE of copy 2 → all outputs reach reset values. After release with `enable`=1, the first `start` follows the first tick at T+2.
